// File: rtl/immediate_fetch_pkg.sv
// Shared types and widths for the immediate operand fetch unit.
package immediate_fetch_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IMM_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LO_REQ = 3'd1,
    LO_CAP = 3'd2,
    HI_REQ = 3'd3,
    HI_CAP = 3'd4
  } ImmFetchState_t;

  // Upper byte for a single-byte immediate: replicated sign bit or zero.
  function automatic logic [BYTE_W-1:0] ext_hi(input logic [BYTE_W-1:0] b,
                                               input logic sext);
    return sext ? {BYTE_W{b[BYTE_W-1]}} : BYTE_W'(0);
  endfunction

endpackage

// File: rtl/immediate_fetch.sv
// Pulls an 8/16-bit immediate from the prefetch FIFO byte by byte and
// presents it as the ALU b operand.
module immediate_fetch
  import immediate_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_8_bit,
  input  logic              sign_extend,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [BYTE_W-1:0] fifo_rd_data,
  output logic              busy,
  output logic              complete,
  output logic [IMM_W-1:0]  immediate
);

  ImmFetchState_t    state_q, state_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic              complete_d;
  logic              is8_q, is8_d;
  logic              sext_q, sext_d;

  // State, operand and mode registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      imm_q    <= IMM_W'(0);
      complete <= 1'b0;
      is8_q    <= 1'b0;
      sext_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      imm_q    <= imm_d;
      complete <= complete_d;
      is8_q    <= is8_d;
      sext_q   <= sext_d;
    end
  end

  // Next-state, FIFO pop and operand assembly; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    imm_d      = imm_q;
    complete_d = 1'b0;
    is8_d      = is8_q;
    sext_d     = sext_q;
    fifo_rd_en = 1'b0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            is8_d   = is_8_bit;
            sext_d  = sign_extend;
            state_d = LO_REQ;
          end
        end
        LO_REQ: begin
          fifo_rd_en = !fifo_empty;
          if (!fifo_empty) state_d = LO_CAP;
        end
        LO_CAP: begin
          imm_d[BYTE_W-1:0] = fifo_rd_data;
          if (is8_q) begin
            imm_d[IMM_W-1:BYTE_W] = ext_hi(fifo_rd_data, sext_q);
            complete_d            = 1'b1;
            state_d               = IDLE;
          end else begin
            // Pop the high byte in the same cycle the low byte lands.
            fifo_rd_en = !fifo_empty;
            state_d    = fifo_empty ? HI_REQ : HI_CAP;
          end
        end
        HI_REQ: begin
          fifo_rd_en = !fifo_empty;
          if (!fifo_empty) state_d = HI_CAP;
        end
        HI_CAP: begin
          imm_d[IMM_W-1:BYTE_W] = fifo_rd_data;
          complete_d            = 1'b1;
          state_d               = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign immediate = imm_q;

endmodule

// File: tb/tb_immediate_fetch.sv
// Directed bench for immediate_fetch with a small 1-cycle-latency FIFO model.
module tb_immediate_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, is_8_bit, sign_extend, flush;
  logic        fifo_empty, fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        busy, complete;
  logic [15:0] immediate;

  logic [7:0]  fq[$];
  logic        stall;
  int          n_tests = 0;
  int          n_fail  = 0;

  immediate_fetch dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .is_8_bit     (is_8_bit),
    .sign_extend  (sign_extend),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .busy         (busy),
    .complete     (complete),
    .immediate    (immediate)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is8;
    logic        sext;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          st_lo;
    int          st_hi;
    int          start_len;
    logic [15:0] exp_imm;
    int          exp_edge;
    logic [31:0] exp_mask;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = stall || (fq.size() == 0);
  endtask

  // One clock: rd_en seen by the edge, then post-edge registered outputs.
  task automatic step(output logic rd, output logic cmp);
    @(negedge clk);
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) fifo_rd_data = fq.pop_front();
    cmp = complete;
    upd_empty();
  endtask

  task automatic run_fetch(input vec_t v, input string tag);
    logic        rd, cmp;
    int          cmp_edge;
    int          ncmp;
    logic [31:0] mask;
    cmp_edge = -1;
    ncmp     = 0;
    mask     = '0;
    fq.push_back(v.b0);
    if (!v.is8) fq.push_back(v.b1);
    is_8_bit    = v.is8;
    sign_extend = v.sext;
    for (int e = 0; e < 20; e++) begin
      start = (e < v.start_len);
      stall = (e >= v.st_lo) && (e <= v.st_hi);
      upd_empty();
      step(rd, cmp);
      if (rd) mask[e] = 1'b1;
      if (cmp) begin
        ncmp++;
        if (cmp_edge < 0) cmp_edge = e;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    check({tag, ".imm"},   32'(immediate), 32'(v.exp_imm));
    check({tag, ".edge"},  32'(cmp_edge),  32'(v.exp_edge));
    check({tag, ".rd"},    mask,           v.exp_mask);
    check({tag, ".ncmp"},  32'(ncmp),      32'd1);
    check({tag, ".busy"},  32'(busy),      32'd0);
    check({tag, ".fifo"},  32'(fq.size()), 32'd0);
    fq.delete();
    upd_empty();
  endtask

  initial begin
    logic        rd, cmp;
    logic [15:0] held;
    vec_t        v;

    // is8 sext b0 b1 st_lo st_hi start_len imm edge rd-mask
    vecs.push_back('{1'b1, 1'b0, 8'hF0, 8'h00, 99, -1, 1, 16'h00F0, 2, 32'h2});
    vecs.push_back('{1'b1, 1'b1, 8'h80, 8'h00, 99, -1, 1, 16'hFF80, 2, 32'h2});
    vecs.push_back('{1'b1, 1'b1, 8'h7F, 8'h00, 99, -1, 1, 16'h007F, 2, 32'h2});
    vecs.push_back('{1'b1, 1'b0, 8'h80, 8'h00, 99, -1, 1, 16'h0080, 2, 32'h2});
    vecs.push_back('{1'b0, 1'b0, 8'h34, 8'h12, 99, -1, 1, 16'h1234, 3, 32'h6});
    vecs.push_back('{1'b0, 1'b1, 8'h85, 8'h00, 99, -1, 1, 16'h0085, 3, 32'h6});
    vecs.push_back('{1'b0, 1'b0, 8'h34, 8'h12,  2,  4, 1, 16'h1234, 6, 32'h22});
    vecs.push_back('{1'b1, 1'b1, 8'h5A, 8'h00,  1,  2, 1, 16'h005A, 4, 32'h8});
    vecs.push_back('{1'b0, 1'b0, 8'h5A, 8'hA5, 99, -1, 4, 16'hA55A, 3, 32'h6});
    vecs.push_back('{1'b0, 1'b0, 8'hAB, 8'hCD, 99, -1, 1, 16'hCDAB, 3, 32'h6});

    reset_n      = 1'b0;
    start        = 1'b0;
    is_8_bit     = 1'b0;
    sign_extend  = 1'b0;
    flush        = 1'b0;
    stall        = 1'b0;
    fifo_rd_data = 8'h00;
    upd_empty();
    #1;
    check("rst.busy",  32'(busy),       32'd0);
    check("rst.cmp",   32'(complete),   32'd0);
    check("rst.imm",   32'(immediate),  32'd0);
    check("rst.rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_fetch(v, $sformatf("vec%0d", i));
    end

    // Flush while the low byte is being captured on a 16-bit fetch.
    held = immediate;
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    upd_empty();
    is_8_bit = 1'b0;
    start    = 1'b1;
    step(rd, cmp);
    start = 1'b0;
    step(rd, cmp);
    check("flush.pop_lo", 32'(rd), 32'd1);
    flush = 1'b1;
    step(rd, cmp);
    flush = 1'b0;
    check("flush.rd_en", 32'(rd),        32'd0);
    check("flush.cmp",   32'(cmp),       32'd0);
    check("flush.busy",  32'(busy),      32'd0);
    check("flush.imm",   32'(immediate), 32'(held));
    step(rd, cmp);
    step(rd, cmp);
    check("flush.idle_rd", 32'(rd),        32'd0);
    check("flush.idle_cmp", 32'(cmp),      32'd0);
    check("flush.left",    32'(fq.size()), 32'd1);
    fq.delete();
    upd_empty();

    // Flush and start together in IDLE: flush wins.
    fq.push_back(8'h99);
    upd_empty();
    start = 1'b1;
    flush = 1'b1;
    step(rd, cmp);
    start = 1'b0;
    flush = 1'b0;
    check("flstart.busy", 32'(busy), 32'd0);
    step(rd, cmp);
    check("flstart.rd", 32'(rd), 32'd0);
    fq.delete();
    upd_empty();

    v = '{1'b1, 1'b1, 8'hC3, 8'h00, 99, -1, 1, 16'hFFC3, 2, 32'h2};
    run_fetch(v, "postflush");

    // Async reset while waiting for the high byte.
    fq.push_back(8'h34);
    upd_empty();
    is_8_bit = 1'b0;
    start    = 1'b1;
    step(rd, cmp);
    start = 1'b0;
    step(rd, cmp);
    step(rd, cmp);
    check("hireq.busy", 32'(busy), 32'd1);
    fq.push_back(8'h12);
    upd_empty();
    #1;
    check("hireq.rd_en", 32'(fifo_rd_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst.busy",  32'(busy),       32'd0);
    check("midrst.imm",   32'(immediate),  32'd0);
    check("midrst.cmp",   32'(complete),   32'd0);
    check("midrst.rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    fq.delete();
    upd_empty();
    @(posedge clk);
    #1;

    v = '{1'b0, 1'b0, 8'h34, 8'h12, 99, -1, 1, 16'h1234, 3, 32'h6};
    run_fetch(v, "postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
